// File: rtl/sync_fifo_param_if.sv
// ---------------------------------------------------------------------------
// sync_fifo_param_if
//
// Purpose: bundles the write/read handshake, data and status signals of the
// parametrised single-clock FIFO so producer, consumer and FIFO share one
// port object. Clock and reset are kept outside as plain ports.
//
// Parameters:
//   WIDTH  data width in bits
//   DEPTH  number of FIFO entries (sets the width of count)
//
// Signals:
//   wr_en, din          write request and write data      (master -> FIFO)
//   rd_en               read request / pop                (master -> FIFO)
//   dout                read data                         (FIFO -> master)
//   full, empty         occupancy == DEPTH / == 0         (FIFO -> master)
//   almost_full/empty   threshold flags                   (FIFO -> master)
//   count               exact occupancy 0..DEPTH          (FIFO -> master)
//   overflow/underflow  sticky error flags                (FIFO -> master)
//
// Modports:
//   master  the producer/consumer side driving requests
//   slave   the FIFO side
// ---------------------------------------------------------------------------
interface sync_fifo_param_if #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 128
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             wr_en;
    logic [WIDTH-1:0] din;
    logic             rd_en;
    logic [WIDTH-1:0] dout;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;

    modport master (
        output wr_en, din, rd_en,
        input  dout, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  wr_en, din, rd_en,
        output dout, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_param.sv
// ---------------------------------------------------------------------------
// sync_fifo_param
//
// Purpose: parametrised single-clock FIFO for io_ctrl datapaths. Supports any
// DEPTH >= 2 (not only powers of two), a standard registered read or a
// first-word-fall-through read, configurable almost-full/almost-empty
// thresholds, exact occupancy and sticky overflow/underflow error flags.
//
// Parameters:
//   WIDTH          data width in bits (>= 1)
//   DEPTH          number of entries (>= 2)
//   FWFT           0 = registered read (1-cycle latency), 1 = fall-through
//   AFULL_THRESH   almost_full  when count >= AFULL_THRESH  (1..DEPTH)
//   AEMPTY_THRESH  almost_empty when count <= AEMPTY_THRESH (0..DEPTH-1)
//
// Ports:
//   clk   single clock, all logic on posedge
//   rst   synchronous active-high reset
//   bus   sync_fifo_param_if.slave: wr_en/din, rd_en/dout, full, empty,
//         almost_full, almost_empty, count, overflow, underflow
// ---------------------------------------------------------------------------
module sync_fifo_param #(
    parameter int WIDTH         = 64,
    parameter int DEPTH         = 128,
    parameter int FWFT          = 0,
    parameter int AFULL_THRESH  = DEPTH - 4,
    parameter int AEMPTY_THRESH = 4
) (
    input  logic               clk,
    input  logic               rst,
    sync_fifo_param_if.slave   bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    // Reject illegal configurations at elaboration time.
    if (WIDTH < 1) begin : g_bad_width
        $error("sync_fifo_param: WIDTH must be >= 1");
    end
    if (DEPTH < 2) begin : g_bad_depth
        $error("sync_fifo_param: DEPTH must be >= 2");
    end
    if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_afull
        $error("sync_fifo_param: AFULL_THRESH must be in 1..DEPTH");
    end
    if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > DEPTH - 1) begin : g_bad_aempty
        $error("sync_fifo_param: AEMPTY_THRESH must be in 0..DEPTH-1");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic             overflow_q;
    logic             underflow_q;
    logic             full_w;
    logic             empty_w;
    logic             wr_acc;
    logic             rd_acc;

    // Pointers wrap explicitly at DEPTH-1 so non-power-of-two depths work.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    // Status comes only from the registered count, never from this cycle's
    // requests, so a write while full is rejected even if a read is accepted
    // in the same cycle (and symmetrically for a read while empty).
    assign full_w  = (count_q == CW'(DEPTH));
    assign empty_w = (count_q == '0);
    assign wr_acc  = bus.wr_en & ~full_w;
    assign rd_acc  = bus.rd_en & ~empty_w;

    assign bus.full         = full_w;
    assign bus.empty        = empty_w;
    assign bus.almost_full  = (count_q >= CW'(AFULL_THRESH));
    assign bus.almost_empty = (count_q <= CW'(AEMPTY_THRESH));
    assign bus.count        = count_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

    // Storage array: no reset, contents survive rst. Writes are blocked
    // during reset so a reset cycle has no side effects at all.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            mem[wr_ptr] <= bus.din;
        end
    end

    // Pointers, occupancy and sticky error flags. A simultaneous accepted
    // read and write leaves the count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (rd_acc) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({wr_acc, rd_acc})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            if (bus.wr_en && full_w) begin
                overflow_q <= 1'b1;
            end
            if (bus.rd_en && empty_w) begin
                underflow_q <= 1'b1;
            end
        end
    end

    if (FWFT != 0) begin : g_fwft
        // Head entry is visible without a request; forced to zero when empty
        // so stale memory contents never leak out.
        assign bus.dout = empty_w ? '0 : mem[rd_ptr];
    end else begin : g_std
        logic [WIDTH-1:0] dout_q;

        // Registered read: loads on an accepted read, holds otherwise.
        always_ff @(posedge clk) begin
            if (rst) begin
                dout_q <= '0;
            end else if (rd_acc) begin
                dout_q <= mem[rd_ptr];
            end
        end

        assign bus.dout = dout_q;
    end
endmodule

// File: tb/tb_sync_fifo_param.sv
// ---------------------------------------------------------------------------
// tb_sync_fifo_param
//
// Purpose: self-checking bench for sync_fifo_param. Two instances are used:
//   dut_a  standard read, WIDTH=64, DEPTH=128, thresholds 124 / 4
//   dut_b  FWFT read,     WIDTH=16, DEPTH=5,   thresholds 4 / 1
// Each keeps a queue-based reference model; expected values come from the
// model or from constants.
// ---------------------------------------------------------------------------
module tb_sync_fifo_param;
    localparam int W_A  = 64;
    localparam int D_A  = 128;
    localparam int CW_A = $clog2(D_A + 1);
    localparam int W_B  = 16;
    localparam int D_B  = 5;
    localparam int CW_B = $clog2(D_B + 1);

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    sync_fifo_param_if #(.WIDTH(W_A), .DEPTH(D_A)) bus_a ();
    sync_fifo_param_if #(.WIDTH(W_B), .DEPTH(D_B)) bus_b ();

    sync_fifo_param #(
        .WIDTH(W_A), .DEPTH(D_A), .FWFT(0),
        .AFULL_THRESH(D_A - 4), .AEMPTY_THRESH(4)
    ) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    sync_fifo_param #(
        .WIDTH(W_B), .DEPTH(D_B), .FWFT(1),
        .AFULL_THRESH(4), .AEMPTY_THRESH(1)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    // Reference models: plain queues plus sticky bits.
    logic [W_A-1:0] q_a[$];
    logic [W_A-1:0] dout_a_m;
    bit             ovf_a_m;
    bit             unf_a_m;
    logic [W_B-1:0] q_b[$];
    bit             ovf_b_m;
    bit             unf_b_m;

    int checks = 0;
    int errors = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_a(input bit wr, input logic [W_A-1:0] d, input bit rd);
        bit wr_ok;
        bit rd_ok;
        wr_ok = wr && (q_a.size() < D_A);
        rd_ok = rd && (q_a.size() > 0);
        if (wr && !wr_ok) ovf_a_m = 1'b1;
        if (rd && !rd_ok) unf_a_m = 1'b1;
        if (rd_ok) dout_a_m = q_a.pop_front();
        if (wr_ok) q_a.push_back(d);
    endtask

    task automatic model_b(input bit wr, input logic [W_B-1:0] d, input bit rd);
        bit wr_ok;
        bit rd_ok;
        wr_ok = wr && (q_b.size() < D_B);
        rd_ok = rd && (q_b.size() > 0);
        if (wr && !wr_ok) ovf_b_m = 1'b1;
        if (rd && !rd_ok) unf_b_m = 1'b1;
        if (rd_ok) void'(q_b.pop_front());
        if (wr_ok) q_b.push_back(d);
    endtask

    // {full, empty, almost_full, almost_empty, overflow, underflow}
    function automatic logic [5:0] exp_flags_a();
        int n;
        n = q_a.size();
        return {n == D_A, n == 0, n >= D_A - 4, n <= 4, ovf_a_m, unf_a_m};
    endfunction

    function automatic logic [5:0] exp_flags_b();
        int n;
        n = q_b.size();
        return {n == D_B, n == 0, n >= 4, n <= 1, ovf_b_m, unf_b_m};
    endfunction

    function automatic logic [W_B-1:0] exp_head_b();
        return (q_b.size() == 0) ? '0 : q_b[0];
    endfunction

    task automatic step_a(input bit wr, input logic [W_A-1:0] d, input bit rd);
        bus_a.wr_en = wr;
        bus_a.din   = d;
        bus_a.rd_en = rd;
        model_a(wr, d, rd);
        tick();
        bus_a.wr_en = 1'b0;
        bus_a.rd_en = 1'b0;
    endtask

    task automatic step_b(input bit wr, input logic [W_B-1:0] d, input bit rd);
        bus_b.wr_en = wr;
        bus_b.din   = d;
        bus_b.rd_en = rd;
        model_b(wr, d, rd);
        tick();
        bus_b.wr_en = 1'b0;
        bus_b.rd_en = 1'b0;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        bus_a.wr_en = 1'b0;
        bus_a.rd_en = 1'b0;
        bus_a.din   = '0;
        bus_b.wr_en = 1'b0;
        bus_b.rd_en = 1'b0;
        bus_b.din   = '0;
        tick();
        rst = 1'b0;
        q_a.delete();
        q_b.delete();
        dout_a_m = '0;
        ovf_a_m  = 1'b0;
        unf_a_m  = 1'b0;
        ovf_b_m  = 1'b0;
        unf_b_m  = 1'b0;
    endtask

    // Reset then idle: everything at its reset value.
    task automatic test_reset();
        do_reset();
        tick();
        checks++;
        if (bus_a.count !== CW_A'(0)) begin
            errors++; $display("[TB] FAIL reset_count got %0d want 0", bus_a.count);
        end
        checks++;
        if ({bus_a.full, bus_a.empty, bus_a.almost_full, bus_a.almost_empty,
             bus_a.overflow, bus_a.underflow} !== 6'b010100) begin
            errors++;
            $display("[TB] FAIL reset_flags got %b want 010100",
                     {bus_a.full, bus_a.empty, bus_a.almost_full, bus_a.almost_empty,
                      bus_a.overflow, bus_a.underflow});
        end
        checks++;
        if (bus_a.dout !== '0) begin
            errors++; $display("[TB] FAIL reset_dout got %h want 0", bus_a.dout);
        end
        checks++;
        if ({bus_b.count, bus_b.empty, bus_b.dout} !== {CW_B'(0), 1'b1, 16'h0000}) begin
            errors++;
            $display("[TB] FAIL reset_b got count=%0d empty=%b dout=%h want 0/1/0",
                     bus_b.count, bus_b.empty, bus_b.dout);
        end
    endtask

    // Fill 128 back-to-back, one rejected write, then drain in order.
    task automatic test_fill_drain();
        do_reset();
        for (int i = 0; i < D_A; i++) begin
            step_a(1'b1, W_A'(i), 1'b0);
            checks++;
            if (bus_a.count !== CW_A'(i + 1)) begin
                errors++; $display("[TB] FAIL fill_count got %0d want %0d", bus_a.count, i + 1);
            end
            checks++;
            if ({bus_a.full, bus_a.almost_full} !== {i + 1 == D_A, i + 1 >= D_A - 4}) begin
                errors++;
                $display("[TB] FAIL fill_flags at count %0d got full=%b af=%b",
                         i + 1, bus_a.full, bus_a.almost_full);
            end
        end
        step_a(1'b1, 64'hDEAD, 1'b0);
        checks++;
        if ({bus_a.overflow, bus_a.full, bus_a.count} !== {1'b1, 1'b1, CW_A'(D_A)}) begin
            errors++;
            $display("[TB] FAIL overflow got ovf=%b full=%b count=%0d want 1/1/128",
                     bus_a.overflow, bus_a.full, bus_a.count);
        end
        for (int i = 0; i < D_A; i++) begin
            step_a(1'b0, '0, 1'b1);
            checks++;
            if (bus_a.dout !== W_A'(i)) begin
                errors++; $display("[TB] FAIL drain_dout got %h want %h", bus_a.dout, W_A'(i));
            end
        end
        checks++;
        if ({bus_a.empty, bus_a.count, bus_a.underflow} !== {1'b1, CW_A'(0), 1'b0}) begin
            errors++;
            $display("[TB] FAIL drain_end got empty=%b count=%0d unf=%b want 1/0/0",
                     bus_a.empty, bus_a.count, bus_a.underflow);
        end
    endtask

    // DEPTH=5: 20 interleaved writes/reads wrap the pointers several times,
    // then 10 cycles of concurrent read+write at occupancy 3.
    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            step_b(1'b1, W_B'(16'h0100 + i), i >= 2);
            checks++;
            if ({bus_b.count, bus_b.dout} !== {CW_B'(q_b.size()), exp_head_b()}) begin
                errors++;
                $display("[TB] FAIL wrap_io got count=%0d dout=%h want %0d/%h",
                         bus_b.count, bus_b.dout, q_b.size(), exp_head_b());
            end
        end
        while (q_b.size() > 0) begin
            step_b(1'b0, '0, 1'b1);
            checks++;
            if (bus_b.dout !== exp_head_b()) begin
                errors++; $display("[TB] FAIL wrap_drain got %h want %h", bus_b.dout, exp_head_b());
            end
        end
        for (int i = 0; i < 3; i++) step_b(1'b1, W_B'(16'h0200 + i), 1'b0);
        for (int i = 0; i < 10; i++) begin
            step_b(1'b1, W_B'(16'h0300 + i), 1'b1);
            checks++;
            if (bus_b.count !== CW_B'(3)) begin
                errors++; $display("[TB] FAIL concurrent_count got %0d want 3", bus_b.count);
            end
            checks++;
            if (bus_b.dout !== exp_head_b()) begin
                errors++; $display("[TB] FAIL concurrent_head got %h want %h", bus_b.dout, exp_head_b());
            end
        end
    endtask

    // FWFT: first write visible only after the write edge; a pop empties it.
    task automatic test_fwft();
        do_reset();
        bus_b.wr_en = 1'b1;
        bus_b.din   = 16'h00A5;
        #1;
        checks++;
        if ({bus_b.dout, bus_b.empty} !== {16'h0000, 1'b1}) begin
            errors++;
            $display("[TB] FAIL fwft_write_cycle got dout=%h empty=%b want 0000/1", bus_b.dout, bus_b.empty);
        end
        step_b(1'b1, 16'h00A5, 1'b0);
        checks++;
        if ({bus_b.dout, bus_b.empty} !== {16'h00A5, 1'b0}) begin
            errors++;
            $display("[TB] FAIL fwft_visible got dout=%h empty=%b want 00a5/0", bus_b.dout, bus_b.empty);
        end
        step_b(1'b0, '0, 1'b1);
        checks++;
        if ({bus_b.dout, bus_b.empty} !== {16'h0000, 1'b1}) begin
            errors++;
            $display("[TB] FAIL fwft_pop got dout=%h empty=%b want 0000/1", bus_b.dout, bus_b.empty);
        end
    endtask

    // Read while empty with a concurrent write; write while full with a
    // concurrent read.
    task automatic test_under_over();
        do_reset();
        step_a(1'b1, 64'h77, 1'b0);
        step_a(1'b0, '0, 1'b1);
        step_a(1'b1, 64'h11, 1'b1);
        checks++;
        if ({bus_a.count, bus_a.underflow, bus_a.overflow, bus_a.dout}
                !== {CW_A'(1), 1'b1, 1'b0, 64'h77}) begin
            errors++;
            $display("[TB] FAIL underflow got count=%0d unf=%b ovf=%b dout=%h want 1/1/0/77",
                     bus_a.count, bus_a.underflow, bus_a.overflow, bus_a.dout);
        end
        for (int i = 0; i < D_A - 1; i++) step_a(1'b1, W_A'(64'h1000 + i), 1'b0);
        step_a(1'b1, 64'hBEEF, 1'b1);
        checks++;
        if ({bus_a.count, bus_a.overflow, bus_a.full, bus_a.dout}
                !== {CW_A'(D_A - 1), 1'b1, 1'b0, 64'h11}) begin
            errors++;
            $display("[TB] FAIL full_concurrent got count=%0d ovf=%b full=%b dout=%h want 127/1/0/11",
                     bus_a.count, bus_a.overflow, bus_a.full, bus_a.dout);
        end
        for (int i = 0; i < D_A - 1; i++) step_a(1'b0, '0, 1'b1);
        checks++;
        if ({bus_a.dout, bus_a.empty} !== {64'h107E, 1'b1}) begin
            errors++;
            $display("[TB] FAIL full_drain_last got dout=%h empty=%b want 107e/1", bus_a.dout, bus_a.empty);
        end
    endtask

    // Reset in the middle of a burst with both requests active.
    task automatic test_reset_mid_burst();
        do_reset();
        step_a(1'b0, '0, 1'b1);
        for (int i = 0; i < 60; i++) step_a(1'b1, {$urandom, $urandom}, 1'b0);
        step_a(1'b0, '0, 1'b1);
        bus_a.wr_en = 1'b1;
        bus_a.rd_en = 1'b1;
        bus_a.din   = 64'hFFFF;
        do_reset();
        checks++;
        if ({bus_a.count, bus_a.empty, bus_a.overflow, bus_a.underflow, bus_a.dout}
                !== {CW_A'(0), 1'b1, 1'b0, 1'b0, 64'h0}) begin
            errors++;
            $display("[TB] FAIL mid_burst_reset got count=%0d empty=%b ovf=%b unf=%b dout=%h",
                     bus_a.count, bus_a.empty, bus_a.overflow, bus_a.underflow, bus_a.dout);
        end
        for (int i = 0; i < 3; i++) step_a(1'b1, W_A'(64'hC0 + i), 1'b0);
        for (int i = 0; i < 3; i++) begin
            step_a(1'b0, '0, 1'b1);
            checks++;
            if (bus_a.dout !== W_A'(64'hC0 + i)) begin
                errors++; $display("[TB] FAIL restart_dout got %h want %h", bus_a.dout, W_A'(64'hC0 + i));
            end
        end
    endtask

    // Random traffic on both FIFOs: a write-heavy phase then a read-heavy one.
    task automatic test_random();
        bit             wa, ra, wb, rb;
        logic [W_A-1:0] da;
        logic [W_B-1:0] db;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if (i < 300) begin
                wa = ($urandom_range(0, 9) < 8);
                ra = ($urandom_range(0, 9) < 2);
                wb = ($urandom_range(0, 9) < 7);
                rb = ($urandom_range(0, 9) < 3);
            end else begin
                wa = ($urandom_range(0, 9) < 2);
                ra = ($urandom_range(0, 9) < 8);
                wb = ($urandom_range(0, 9) < 3);
                rb = ($urandom_range(0, 9) < 7);
            end
            da = {$urandom, $urandom};
            db = W_B'($urandom);
            bus_a.wr_en = wa; bus_a.rd_en = ra; bus_a.din = da;
            bus_b.wr_en = wb; bus_b.rd_en = rb; bus_b.din = db;
            model_a(wa, da, ra);
            model_b(wb, db, rb);
            tick();
            checks++;
            if ({bus_a.count, bus_a.dout} !== {CW_A'(q_a.size()), dout_a_m}) begin
                errors++;
                $display("[TB] FAIL rand_a_data got count=%0d dout=%h want %0d/%h",
                         bus_a.count, bus_a.dout, q_a.size(), dout_a_m);
            end
            checks++;
            if ({bus_a.full, bus_a.empty, bus_a.almost_full, bus_a.almost_empty,
                 bus_a.overflow, bus_a.underflow} !== exp_flags_a()) begin
                errors++;
                $display("[TB] FAIL rand_a_flags got %b want %b",
                         {bus_a.full, bus_a.empty, bus_a.almost_full, bus_a.almost_empty,
                          bus_a.overflow, bus_a.underflow}, exp_flags_a());
            end
            checks++;
            if ({bus_b.count, bus_b.dout} !== {CW_B'(q_b.size()), exp_head_b()}) begin
                errors++;
                $display("[TB] FAIL rand_b_data got count=%0d dout=%h want %0d/%h",
                         bus_b.count, bus_b.dout, q_b.size(), exp_head_b());
            end
            checks++;
            if ({bus_b.full, bus_b.empty, bus_b.almost_full, bus_b.almost_empty,
                 bus_b.overflow, bus_b.underflow} !== exp_flags_b()) begin
                errors++;
                $display("[TB] FAIL rand_b_flags got %b want %b",
                         {bus_b.full, bus_b.empty, bus_b.almost_full, bus_b.almost_empty,
                          bus_b.overflow, bus_b.underflow}, exp_flags_b());
            end
        end
        bus_a.wr_en = 1'b0; bus_a.rd_en = 1'b0;
        bus_b.wr_en = 1'b0; bus_b.rd_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_wrap();
        test_fwft();
        test_under_over();
        test_reset_mid_burst();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
